// File: rtl/iir_biquad_mac.sv
// Direct-form-I biquad; one multiplier shared over five MAC cycles, shadow/active coefficient sets.
// Optional `BIQUAD_BYPASS_EN adds a bypass input that forwards a sample in one cycle.
module iir_biquad_mac #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    parameter int ACCW = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 coef_we,
    input  logic [2:0]           coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
`ifdef BIQUAD_BYPASS_EN
    input  logic                 bypass,
`endif
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 overflow
);

    localparam int PW = DW + CW;
    localparam logic signed [CW-1:0]   ONE  = CW'(64'd1 << FRAC);
    localparam logic signed [ACCW-1:0] HALF = ACCW'(64'd1 << (FRAC - 1));
    localparam logic signed [ACCW-1:0] MAXV = ACCW'((64'd1 << (DW - 1)) - 64'd1);
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [DW-1:0]   x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic signed [CW-1:0]   shadow_q [5];
    logic signed [CW-1:0]   shadow_d [5];
    logic signed [CW-1:0]   active_q [5];
    logic signed [CW-1:0]   active_d [5];

    logic signed [CW-1:0]   mul_c;
    logic signed [DW-1:0]   mul_s;
    logic                   mul_neg;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] term, rnd, r;
    logic signed [DW-1:0]   sat_val;
    logic                   sat_hit;

    assign in_ready  = (state_q == IDLE) && !clear;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = ovf_q;

    // Feedback terms are subtracted, so a1/a2 hold the coefficients as written.
    always_comb begin
        mul_c   = active_q[0];
        mul_s   = x0_q;
        mul_neg = 1'b0;
        case (idx_q)
            3'd1: begin mul_c = active_q[1]; mul_s = x1_q; end
            3'd2: begin mul_c = active_q[2]; mul_s = x2_q; end
            3'd3: begin mul_c = active_q[3]; mul_s = y1_q; mul_neg = 1'b1; end
            3'd4: begin mul_c = active_q[4]; mul_s = y2_q; mul_neg = 1'b1; end
            default: ;
        endcase
        prod = PW'(mul_c) * PW'(mul_s);
        term = mul_neg ? -ACCW'(prod) : ACCW'(prod);
    end

    always_comb begin
        rnd     = acc_q + HALF;
        r       = rnd >>> FRAC;
        sat_hit = 1'b0;
        sat_val = r[DW-1:0];
        if (r > MAXV) begin
            sat_val = {1'b0, {(DW-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (r < MINV) begin
            sat_val = {1'b1, {(DW-1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        shadow_d    = shadow_q;
        active_d    = active_q;
        if (coef_we && (coef_addr < 3'd5)) shadow_d[coef_addr] = coef_wdata;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                x0_d     = in_data;
                active_d = shadow_q;
                acc_d    = '0;
                idx_d    = '0;
                state_d  = MAC;
`ifdef BIQUAD_BYPASS_EN
                if (bypass) begin
                    state_d     = IDLE;
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    x2_d        = x1_q;
                    x1_d        = in_data;
                    y2_d        = y1_q;
                    y1_d        = in_data;
                end
`endif
            end
            MAC: begin
                acc_d = acc_q + term;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd4) state_d = DONE;
            end
            DONE: begin
                out_data_d  = sat_val;
                out_valid_d = 1'b1;
                ovf_d       = ovf_q | sat_hit;
                x2_d        = x1_q;
                x1_d        = x0_q;
                y2_d        = y1_q;
                y1_d        = sat_val;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d     = IDLE;
            idx_d       = '0;
            acc_d       = '0;
            x1_d        = '0;
            x2_d        = '0;
            y1_d        = '0;
            y2_d        = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) begin
                shadow_q[i] <= (i == 0) ? ONE : '0;
                active_q[i] <= (i == 0) ? ONE : '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

endmodule
